// File: rtl/wb_regfile_sb.sv
// Writeback end of the pipeline: 32-entry integer register file with same-cycle write bypass on
// both decode read ports, plus a load scoreboard that raises a load-use stall toward ID.
module wb_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_load,
  output logic              stall,
  output logic              pending_any
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pendNext;

  logic rs1Valid, rs2Valid, wbValid, rdValid;
  logic hz1, hz2;
  logic wbCommit, loadSet;

  // Addresses beyond the implemented registers behave like reg 0: read 0, never written.
  generate
    if (NUM_REGS < (1 << ADDR_W)) begin : gPartial
      assign rs1Valid = int'(rs1_addr) < NUM_REGS;
      assign rs2Valid = int'(rs2_addr) < NUM_REGS;
      assign wbValid  = int'(wb_addr)  < NUM_REGS;
      assign rdValid  = int'(issue_rd) < NUM_REGS;
    end else begin : gFull
      assign rs1Valid = 1'b1;
      assign rs2Valid = 1'b1;
      assign wbValid  = 1'b1;
      assign rdValid  = 1'b1;
    end
  endgenerate

  assign wbCommit = wb_we && (wb_addr != '0) && wbValid;

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0 && rs1Valid) begin
      if (wb_we && wb_addr == rs1_addr) rs1_data = wb_data;
      else                              rs1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0 && rs2Valid) begin
      if (wb_we && wb_addr == rs2_addr) rs2_data = wb_data;
      else                              rs2_data = regs[rs2_addr];
    end
  end

  // A pending load is not a hazard in the cycle its result commits; the bypass supplies it.
  assign hz1   = (rs1_addr != '0) && rs1Valid && pend[rs1_addr] && !(wb_we && wb_addr == rs1_addr);
  assign hz2   = (rs2_addr != '0) && rs2Valid && pend[rs2_addr] && !(wb_we && wb_addr == rs2_addr);
  assign stall = issue_valid && (hz1 || hz2);

  assign loadSet = issue_valid && !stall && issue_load && (issue_rd != '0) && rdValid;

  // Clear first, then set, so a new load to the same register wins over the retiring one.
  always_comb begin
    pendNext = pend;
    if (wbCommit) pendNext[wb_addr] = 1'b0;
    if (loadSet)  pendNext[issue_rd] = 1'b1;
    pendNext[0] = 1'b0;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (wbCommit) regs[wb_addr] <= wb_data;
      pend <= pendNext;
    end
  end

  assign pending_any = |pend;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Scoreboard bench for wb_regfile_sb: stimulus pushes model-predicted outputs into a queue,
// a monitor pops and compares them mid-cycle, well away from the falling edge.
module tb_wb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic [AW-1:0] rs1_addr = '0;
  logic [AW-1:0] rs2_addr = '0;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rd = '0;
  logic          issue_load = 1'b0;
  logic          stall;
  logic          pending_any;

  always #5 clk = ~clk;

  wb_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_load(issue_load),
    .stall(stall), .pending_any(pending_any)
  );

  typedef struct {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic          stall;
    logic          pendAny;
    string         tag;
  } exp_t;

  exp_t expQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: architectural register values and the set of outstanding load destinations.
  logic [DW-1:0] mRegs [NR];
  bit            mPend [NR];

  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a, input logic we,
                                              input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return mRegs[a];
  endfunction

  function automatic bit modelHazard(input logic [AW-1:0] a, input logic we, input logic [AW-1:0] wa);
    return (a != 0) && mPend[a] && !(we && wa == a);
  endfunction

  task automatic checkOutput(input exp_t e);
    testsRun++;
    if (rs1_data !== e.rs1) begin
      testsFailed++;
      $display("[TB] FAIL %s rs1_data: got %h, expected %h", e.tag, rs1_data, e.rs1);
    end
    testsRun++;
    if (rs2_data !== e.rs2) begin
      testsFailed++;
      $display("[TB] FAIL %s rs2_data: got %h, expected %h", e.tag, rs2_data, e.rs2);
    end
    testsRun++;
    if (stall !== e.stall) begin
      testsFailed++;
      $display("[TB] FAIL %s stall: got %b, expected %b", e.tag, stall, e.stall);
    end
    testsRun++;
    if (pending_any !== e.pendAny) begin
      testsFailed++;
      $display("[TB] FAIL %s pending_any: got %b, expected %b", e.tag, pending_any, e.pendAny);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit doCheck, input logic rst,
                               input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                               input logic iv, input logic [AW-1:0] rd, input logic ld);
    exp_t e;
    bit   anyPend;
    @(posedge clk);
    reset = rst; wb_we = we; wb_addr = wa; wb_data = wd;
    rs1_addr = r1; rs2_addr = r2;
    issue_valid = iv; issue_rd = rd; issue_load = ld;

    e.rs1   = modelRead(r1, we, wa, wd);
    e.rs2   = modelRead(r2, we, wa, wd);
    e.stall = iv && (modelHazard(r1, we, wa) || modelHazard(r2, we, wa));
    anyPend = 1'b0;
    foreach (mPend[i]) anyPend |= mPend[i];
    e.pendAny = anyPend;
    e.tag     = tag;
    if (doCheck) expQ.push_back(e);

    // Advance the model to the state after this cycle's falling edge.
    if (rst) begin
      foreach (mRegs[i]) mRegs[i] = '0;
      foreach (mPend[i]) mPend[i] = 1'b0;
    end else begin
      if (we && wa != 0) mRegs[wa] = wd;
      if (we) mPend[wa] = 1'b0;
      if (iv && !e.stall && ld && rd != 0) mPend[rd] = 1'b1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #3;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin : stimulus
    logic [AW-1:0] a1, a2, wa, rd;
    logic          we, iv, ld, rst;

    applyStimulus("reset", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NR; i++)
      applyStimulus("post_reset_read", 1, 0, 0, 0, 0, AW'(i), AW'(NR - 1 - i), 0, 0, 0);

    applyStimulus("bypass_write", 1, 0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
    applyStimulus("after_write",  1, 0, 0, 5, 0, 5, 5, 0, 0, 0);

    applyStimulus("r0_write",      1, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    applyStimulus("r0_after",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus("load_r7",       1, 0, 0, 0, 0, 0, 0, 1, 7, 1);
    applyStimulus("use_r7_stall",  1, 0, 0, 0, 0, 7, 0, 1, 2, 0);
    applyStimulus("use_r7_stall",  1, 0, 0, 0, 0, 7, 0, 1, 2, 0);
    applyStimulus("r7_wb_release", 1, 0, 1, 7, 32'h55, 7, 0, 1, 2, 0);
    applyStimulus("r7_cleared",    1, 0, 0, 0, 0, 7, 0, 1, 2, 0);

    applyStimulus("load_r9",       1, 0, 0, 0, 0, 0, 0, 1, 9, 1);
    applyStimulus("r9_set_clear",  1, 0, 1, 9, 32'hA5A5_0009, 0, 0, 1, 9, 1);
    applyStimulus("use_r9_stall",  1, 0, 0, 0, 0, 0, 9, 1, 1, 0);
    applyStimulus("r9_retire",     1, 0, 1, 9, 32'h9999, 0, 9, 1, 1, 0);

    applyStimulus("write_r3",      1, 0, 1, 3, 32'h3333_3333, 0, 0, 0, 0, 0);
    applyStimulus("load_r3",       1, 0, 0, 0, 0, 3, 0, 1, 3, 1);
    applyStimulus("load_r4",       1, 0, 0, 0, 0, 3, 0, 1, 4, 1);
    applyStimulus("mid_reset",     1, 1, 1, 6, 32'h6666, 3, 4, 1, 5, 1);
    applyStimulus("after_reset",   1, 0, 0, 0, 0, 3, 4, 1, 1, 0);
    applyStimulus("lost_wb_r6",    1, 0, 0, 0, 0, 6, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(79) == 0);
      we  = 1'(($urandom_range(2) != 0));
      wa  = AW'($urandom_range(NR - 1));
      a1  = AW'($urandom_range(NR - 1));
      a2  = AW'($urandom_range(NR - 1));
      iv  = 1'($urandom_range(1));
      rd  = AW'($urandom_range(NR - 1));
      ld  = 1'($urandom_range(1));
      applyStimulus("random", 1, rst, we, wa, $urandom, a1, a2, iv, rd, ld);
    end

    repeat (3) @(posedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d expected entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
